// File: rtl/sop_self_checker.sv
// Stimulus/response engine: walks a 4-input function through all 16 vectors,
// samples OUT at the end of each hold window and scores it against EXPECTED.
module sop_self_checker #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter logic [15:0] EXPECTED    = 16'h6420
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       OUT,
   output logic       A,
   output logic       B,
   output logic       C,
   output logic       D,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [4:0] ERR_CNT,
   output logic [3:0] FIRST_FAIL,
   output logic       FAIL_VALID
);

   localparam int unsigned CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       vec_q, vec_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       err_q, err_d;
   logic [3:0]       ff_q, ff_d;
   logic             fv_q, fv_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   // State and result registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         vec_q   <= 4'd0;
         cnt_q   <= '0;
         err_q   <= 5'd0;
         ff_q    <= 4'd0;
         fv_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         fv_q    <= fv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   // Next-state, scoring and registered-output decode
   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ff_d    = ff_q;
      fv_d    = fv_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (START) begin
               state_d = S_APPLY;
               vec_d   = 4'd0;
               cnt_d   = CNT_RELOAD;
               err_d   = 5'd0;
               ff_d    = 4'd0;
               fv_d    = 1'b0;
            end
         end
         S_APPLY: begin
            if (cnt_q == '0) begin
               // OUT only counts on the last hold cycle, after it has settled
               if (OUT != EXPECTED[vec_q]) begin
                  err_d = err_q + 5'd1;
                  if (!fv_q) begin
                     ff_d = vec_q;
                     fv_d = 1'b1;
                  end
               end
               if (vec_q == 4'hF) begin
                  state_d = S_DONE;
               end else begin
                  vec_d = vec_q + 4'd1;
                  cnt_d = CNT_RELOAD;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d == S_APPLY);
      done_d = (state_d == S_DONE);
      pass_d = done_d && (err_d == 5'd0);
   end

   assign A          = vec_q[3];
   assign B          = vec_q[2];
   assign C          = vec_q[1];
   assign D          = vec_q[0];
   assign BUSY       = busy_q;
   assign DONE       = done_q;
   assign PASS       = pass_q;
   assign ERR_CNT    = err_q;
   assign FIRST_FAIL = ff_q;
   assign FAIL_VALID = fv_q;

endmodule
